// File: rtl/booth_mul_sched_pkg.sv
// Shared definitions for the booth4_mul operand scheduler: FSM state encoding
// and parameter defaults used by the interface and the top level.
package booth_mul_sched_pkg;

    localparam int DEFAULT_TAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_PUSH  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/booth_mul_sched_if.sv
// Signal bundle between the scheduler and its environment: operand stream in,
// booth4_mul start/done handshake, and the tagged result stream out.
interface booth_mul_sched_if
    import booth_mul_sched_pkg::*;
#(
    parameter int WIDTH_M = 8,
    parameter int WIDTH_R = 8,
    parameter int TAG_W   = DEFAULT_TAG_W
);

    logic                       in_vld;
    logic                       in_rdy;
    logic [WIDTH_M-1:0]         in_a;
    logic [WIDTH_R-1:0]         in_b;

    logic                       mul_vld;
    logic [WIDTH_M-1:0]         mul_a;
    logic [WIDTH_R-1:0]         mul_b;
    logic [WIDTH_M+WIDTH_R-1:0] mul_out;
    logic                       mul_done;

    logic                       out_vld;
    logic                       out_rdy;
    logic [WIDTH_M+WIDTH_R-1:0] out_prod;
    logic [TAG_W-1:0]           out_tag;
    logic                       out_err;

    // master is the scheduler itself; slave is the producer/multiplier/consumer side.
    modport master (
        input  in_vld, in_a, in_b, mul_out, mul_done, out_rdy,
        output in_rdy, mul_vld, mul_a, mul_b, out_vld, out_prod, out_tag, out_err
    );

    modport slave (
        output in_vld, in_a, in_b, mul_out, mul_done, out_rdy,
        input  in_rdy, mul_vld, mul_a, mul_b, out_vld, out_prod, out_tag, out_err
    );

endinterface

// File: rtl/booth_sched_fifo.sv
// Synchronous FIFO for operand pairs; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module booth_sched_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; entries are only visible once the pointers say so.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/booth_mul_sched.sv
// Operand scheduler for booth4_mul: queues operand pairs, issues one multiply at a
// time, watches for a hung multiplier and returns tagged results on a valid/ready stream.
module booth_mul_sched
    import booth_mul_sched_pkg::*;
#(
    parameter int WIDTH_M = 8,
    parameter int WIDTH_R = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = DEFAULT_TAG_W
) (
    input logic               clk,
    input logic               rstn,
    booth_mul_sched_if.master bus
);

    localparam int PROD_W = WIDTH_M + WIDTH_R;
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    sched_state_e       state_q;
    logic               mul_vld_q;
    logic [WIDTH_M-1:0] mul_a_q;
    logic [WIDTH_R-1:0] mul_b_q;
    logic [WD_W-1:0]    wd_q;
    logic [WD_W-1:0]    wd_d;
    logic [PROD_W-1:0]  res_prod_q;
    logic               res_err_q;
    logic [TAG_W-1:0]   tag_q;
    logic               out_vld_q;
    logic [PROD_W-1:0]  out_prod_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic               out_err_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [PROD_W-1:0]  fifo_rd_data;
    logic               fifo_push;
    logic               fifo_pop;

    assign bus.in_rdy = !fifo_full;
    assign fifo_push  = bus.in_vld && !fifo_full;
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
    assign wd_d       = wd_q + WD_W'(1);

    booth_sched_fifo #(
        .WIDTH (PROD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (fifo_push),
        .wr_data_i ({bus.in_a, bus.in_b}),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // NOTE: non-blocking throughout so every register samples pre-edge values; later assignments override defaults.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            mul_vld_q  <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            wd_q       <= '0;
            res_prod_q <= '0;
            res_err_q  <= 1'b0;
            tag_q      <= '0;
            out_vld_q  <= 1'b0;
            out_prod_q <= '0;
            out_tag_q  <= '0;
            out_err_q  <= 1'b0;
        end else begin
            mul_vld_q <= 1'b0;
            if (out_vld_q && bus.out_rdy) out_vld_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {mul_a_q, mul_b_q} <= fifo_rd_data;
                        mul_vld_q          <= 1'b1;
                        state_q            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_q    <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the same cycle as the deadline still counts as a product.
                    if (bus.mul_done) begin
                        res_prod_q <= bus.mul_out;
                        res_err_q  <= 1'b0;
                        state_q    <= ST_PUSH;
                    end else if (wd_d == WD_W'(TIMEOUT)) begin
                        res_prod_q <= '0;
                        res_err_q  <= 1'b1;
                        state_q    <= ST_PUSH;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                ST_PUSH: begin
                    if (!out_vld_q || bus.out_rdy) begin
                        out_vld_q  <= 1'b1;
                        out_prod_q <= res_prod_q;
                        out_tag_q  <= tag_q;
                        out_err_q  <= res_err_q;
                        tag_q      <= tag_q + TAG_W'(1);
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mul_vld  = mul_vld_q;
    assign bus.mul_a    = mul_a_q;
    assign bus.mul_b    = mul_b_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.out_prod = out_prod_q;
    assign bus.out_tag  = out_tag_q;
    assign bus.out_err  = out_err_q;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched with a behavioural booth4_mul model
// (unsigned product, done a programmable number of cycles after mul_vld).
module tb_booth_mul_sched;

    localparam int WM = 8;
    localparam int WR = 8;
    localparam int PW = WM + WR;
    localparam int TW = 4;
    localparam int TO = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    booth_mul_sched_if #(.WIDTH_M(WM), .WIDTH_R(WR), .TAG_W(TW)) bus ();

    booth_mul_sched #(
        .WIDTH_M (WM),
        .WIDTH_R (WR),
        .DEPTH   (4),
        .TIMEOUT (TO),
        .TAG_W   (TW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [PW-1:0] prod;
        logic [TW-1:0] tag;
        logic          err;
    } res_t;

    res_t got_q[$];
    int   mv_q[$];
    int   ov_q[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   model_lat = 8;
    int   late_req  = 0;
    int   late_ack  = 0;
    int   m_cnt     = 0;
    logic [PW-1:0] m_prod = '0;
    logic ov_prev   = 1'b0;
    int   acc_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // booth4_mul model; model_lat == 0 means the multiplier never completes
    always @(negedge clk) begin
        bus.mul_done = 1'b0;
        if (late_req != late_ack) begin
            bus.mul_done = 1'b1;
            bus.mul_out  = 16'hDEAD;
            late_ack     = late_req;
        end
        if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                bus.mul_done = 1'b1;
                bus.mul_out  = m_prod;
            end
        end
        if (bus.mul_vld && model_lat > 0) begin
            m_cnt  = model_lat;
            m_prod = PW'(bus.mul_a) * PW'(bus.mul_b);
        end
    end

    always @(negedge clk) begin
        if (bus.mul_vld) mv_q.push_back(cyc);
        if (bus.out_vld && !ov_prev) ov_q.push_back(cyc);
        ov_prev = bus.out_vld;
        if (bus.out_vld && bus.out_rdy)
            got_q.push_back('{prod: bus.out_prod, tag: bus.out_tag, err: bus.out_err});
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exceeded");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int mv_at(input int i);
        return (i < mv_q.size()) ? mv_q[i] : -1000;
    endfunction

    function automatic int ov_at(input int i);
        return (i < ov_q.size()) ? ov_q[i] : -1000;
    endfunction

    // Leaves in_vld high so consecutive calls form a continuous-valid burst.
    task automatic push(input logic [7:0] a, input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_vld = 1'b1;
        bus.in_a   = a;
        bus.in_b   = b;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok      = bus.in_rdy;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        check("push_accepted", 32'(ok), 1);
    endtask

    task automatic wait_res(input int n, input string tag);
        int k = 0;
        while (got_q.size() < n && k < 500) begin
            tick(1);
            k++;
        end
        check(tag, 32'(got_q.size() >= n), 1);
    endtask

    task automatic check_res(input int idx, input logic [PW-1:0] prod, input logic [TW-1:0] tag,
                             input logic err, input string name);
        res_t r;
        r = (idx < got_q.size()) ? got_q[idx] : 'x;
        check({name, "_prod"}, 32'(r.prod), 32'(prod));
        check({name, "_tag"},  32'(r.tag),  32'(tag));
        check({name, "_err"},  32'(r.err),  32'(err));
    endtask

    task automatic do_reset();
        bus.in_vld  = 1'b0;
        bus.in_a    = '0;
        bus.in_b    = '0;
        bus.out_rdy = 1'b1;
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    initial begin
        int g;
        int m;
        int o;
        int a0;
        int a4;
        logic [PW-1:0] exp_burst [6];
        logic [7:0]    burst_a   [6];
        logic [7:0]    burst_b   [6];

        // reset values
        bus.in_vld  = 1'b0;
        bus.in_a    = '0;
        bus.in_b    = '0;
        bus.out_rdy = 1'b0;
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
        check("rst_in_rdy",   bus.in_rdy,   1);
        check("rst_mul_vld",  bus.mul_vld,  0);
        check("rst_mul_a",    bus.mul_a,    0);
        check("rst_mul_b",    bus.mul_b,    0);
        check("rst_out_vld",  bus.out_vld,  0);
        check("rst_out_prod", bus.out_prod, 0);
        check("rst_out_tag",  bus.out_tag,  0);
        check("rst_out_err",  bus.out_err,  0);

        // single op: 0x12 * 0x34 = 0x03A8
        bus.out_rdy = 1'b1;
        g = got_q.size(); m = mv_q.size(); o = ov_q.size();
        push(8'h12, 8'h34);
        bus.in_vld = 1'b0;
        tick(2);
        check("t1_hold_mul_a",   bus.mul_a,   8'h12);
        check("t1_hold_mul_b",   bus.mul_b,   8'h34);
        check("t1_wait_mul_vld", bus.mul_vld, 0);
        wait_res(g + 1, "t1_result_arrives");
        check_res(g, 16'h03A8, 4'd0, 1'b0, "t1");
        check("t1_issue_latency", 32'(mv_at(m) - acc_cyc), 2);
        check("t1_out_latency",   32'(ov_at(o) - mv_at(m)), 10);
        check("t1_mul_vld_count", 32'(mv_q.size() - m), 1);

        // burst of 5 with continuous valid, then a 6th that must wait for a free slot
        do_reset();
        g = got_q.size(); m = mv_q.size();
        burst_a   = '{8'hAB, 8'hFF, 8'h00, 8'h80, 8'h0F, 8'h10};
        burst_b   = '{8'hCD, 8'hFF, 8'h77, 8'h02, 8'h11, 8'h10};
        exp_burst = '{16'h88EF, 16'hFE01, 16'h0000, 16'h0100, 16'h00FF, 16'h0100};
        push(burst_a[0], burst_b[0]);
        a0 = acc_cyc;
        for (int i = 1; i < 5; i++) push(burst_a[i], burst_b[i]);
        a4 = acc_cyc;
        check("t2_burst_no_stall", 32'(a4 - a0), 4);
        check("t2_full_in_rdy", bus.in_rdy, 0);
        push(burst_a[5], burst_b[5]);
        bus.in_vld = 1'b0;
        check("t2_no_bypass_accept", 32'(acc_cyc), 32'(mv_at(m + 1)));
        wait_res(g + 6, "t2_results_arrive");
        for (int i = 0; i < 6; i++) check_res(g + i, exp_burst[i], TW'(i), 1'b0, "t2");
        check("t2_mul_vld_count", 32'(mv_q.size() - m), 6);

        // output stall: first result parked, second held in PUSH, third not issued
        do_reset();
        bus.out_rdy = 1'b0;
        g = got_q.size(); m = mv_q.size(); o = ov_q.size();
        push(8'h21, 8'h03);
        push(8'h11, 8'h11);
        push(8'h02, 8'h02);
        bus.in_vld = 1'b0;
        for (int k = 0; k < 100 && ov_q.size() <= o; k++) tick(1);
        check("t3_first_out_vld", 32'(ov_q.size() > o), 1);
        tick(20);
        check("t3_stall_out_vld",  bus.out_vld,  1);
        check("t3_stall_out_prod", bus.out_prod, 16'h0063);
        check("t3_stall_out_tag",  bus.out_tag,  0);
        check("t3_stall_no_xfer",  32'(got_q.size() - g), 0);
        check("t3_stall_issues",   32'(mv_q.size() - m), 2);
        bus.out_rdy = 1'b1;
        wait_res(g + 3, "t3_results_arrive");
        check_res(g,     16'h0063, 4'd0, 1'b0, "t3_r0");
        check_res(g + 1, 16'h0121, 4'd1, 1'b0, "t3_r1");
        check_res(g + 2, 16'h0004, 4'd2, 1'b0, "t3_r2");

        // timeout, late done ignored, then a normal op
        do_reset();
        model_lat = 0;
        g = got_q.size(); m = mv_q.size(); o = ov_q.size();
        push(8'h05, 8'h06);
        bus.in_vld = 1'b0;
        wait_res(g + 1, "t4_timeout_arrives");
        check_res(g, 16'h0000, 4'd0, 1'b1, "t4_to");
        check("t4_timeout_latency", 32'(ov_at(o) - mv_at(m)), TO + 2);
        tick(4);
        late_req = late_req + 1;
        tick(10);
        check("t4_late_done_no_result", 32'(got_q.size() - g), 1);
        check("t4_late_done_out_vld",   bus.out_vld, 0);
        check("t4_late_done_no_issue",  32'(mv_q.size() - m), 1);
        model_lat = 8;
        push(8'h07, 8'h09);
        bus.in_vld = 1'b0;
        wait_res(g + 2, "t4_recovery_arrives");
        check_res(g + 1, 16'h003F, 4'd1, 1'b0, "t4_ok");
        check("t4_recovery_latency", 32'(ov_at(o + 1) - mv_at(m + 1)), 10);

        // tag wrap over 17 ops
        do_reset();
        model_lat = 3;
        g = got_q.size();
        for (int i = 0; i < 17; i++) push(8'(i), 8'(i + 1));
        bus.in_vld = 1'b0;
        wait_res(g + 17, "t5_results_arrive");
        for (int i = 0; i < 17; i++) check_res(g + i, PW'(i * (i + 1)), TW'(i % 16), 1'b0, "t5");

        // reset mid-WAIT with three entries queued
        do_reset();
        model_lat = 8;
        m = mv_q.size();
        push(8'h31, 8'h02);
        push(8'h32, 8'h03);
        push(8'h33, 8'h04);
        push(8'h34, 8'h05);
        bus.in_vld = 1'b0;
        for (int k = 0; k < 50 && mv_q.size() <= m; k++) tick(1);
        check("t6_issued_before_reset", 32'(mv_q.size() > m), 1);
        tick(3);
        rstn = 1'b0;
        #1;
        check("t6_rst_async_mul_a",   bus.mul_a,   0);
        check("t6_rst_async_out_vld", bus.out_vld, 0);
        tick(2);
        rstn = 1'b1;
        tick(1);
        g = got_q.size(); m = mv_q.size();
        check("t6_post_in_rdy",  bus.in_rdy,  1);
        check("t6_post_mul_vld", bus.mul_vld, 0);
        check("t6_post_out_vld", bus.out_vld, 0);
        tick(15);
        check("t6_no_stale_result", 32'(got_q.size() - g), 0);
        check("t6_fifo_dropped",    32'(mv_q.size() - m), 0);
        push(8'h0A, 8'h0B);
        bus.in_vld = 1'b0;
        wait_res(g + 1, "t6_new_result_arrives");
        check_res(g, 16'h006E, 4'd0, 1'b0, "t6_new");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
